// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus bundle.
// Ports (slave = arbiter side):
//   req      [3:0]  per-core level request, bit i is core i+1
//   we       [3:0]  per-core access type, 1 = write
//   mem_ctrl [12:0] memory control word (DR we, AR en, data en, wren)
//   grant    [3:0]  one-hot owner of the memory port
//   done     [3:0]  one-cycle completion pulse
//   busy            arbiter not idle
interface mem_arbiter_if;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [12:0] mem_ctrl;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;

    modport master (output req, we, input mem_ctrl, grant, done, busy);
    modport slave  (input req, we, output mem_ctrl, grant, done, busy);
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin sequencer for the shared data memory of the 4-core system.
// Grants the single memory port to one core at a time and drives the
// memory control word for the read or write sequence of the owner.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mem_arbiter_if.slave (req, we in; mem_ctrl, grant, done, busy out)
// Parameter RD_LAT (1..4): cycles from the address edge until RAM q is valid.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner; arbitrate pending requests round-robin
// ADDR  | read: drive owner's address onto the RAM
// WAIT  | read: hold address for RD_LAT-1 cycles (down-counter)
// CAPT  | read: keep address, owner's DR latches mem_bus at cycle end
// WR    | write: address, data and wren for exactly one cycle
// DONE  | completion pulse to owner, grant held, requests ignored
module mem_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    logic [2:0]  state, state_nx;
    // ptr doubles as the owner index while a transaction is in flight.
    logic [1:0]  ptr, ptr_nx;
    logic [1:0]  cnt, cnt_nx;
    logic [1:0]  win, cand;
    logic        found;
    logic [3:0]  oh_nx;
    logic [12:0] ctrl_q, ctrl_nx;
    logic [3:0]  grant_q, grant_nx;
    logic [3:0]  done_q, done_nx;
    logic        busy_q, busy_nx;

    // Search starts at ptr+1 so the last winner has lowest priority.
    always_comb begin : pick
        win   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && bus.req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin : next
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (found) begin
                    ptr_nx   = win;
                    state_nx = bus.we[win] ? S_WR : S_ADDR;
                end
            end
            S_ADDR: begin
                if (RD_LAT == 1) begin
                    state_nx = S_CAPT;
                end else begin
                    state_nx = S_WAIT;
                    cnt_nx   = WAIT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt <= 2'd1) begin
                    state_nx = S_CAPT;
                    cnt_nx   = 2'd0;
                end else begin
                    cnt_nx = cnt - 2'd1;
                end
            end
            S_CAPT, S_WR: state_nx = S_DONE;
            default:      state_nx = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so every
    // output is a flop and nothing combinational reaches them from req.
    always_comb begin : outs
        oh_nx    = 4'b0001 << ptr_nx;
        ctrl_nx  = '0;
        grant_nx = '0;
        done_nx  = '0;
        busy_nx  = (state_nx != S_IDLE);
        if (busy_nx) grant_nx = oh_nx;
        case (state_nx)
            S_ADDR, S_WAIT: ctrl_nx[7:4] = oh_nx;
            S_CAPT: begin
                ctrl_nx[7:4] = oh_nx;
                ctrl_nx[3:0] = oh_nx;
            end
            S_WR: begin
                ctrl_nx[7:4]  = oh_nx;
                ctrl_nx[11:8] = oh_nx;
                ctrl_nx[12]   = 1'b1;
            end
            S_DONE:  done_nx = oh_nx;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ptr     <= 2'd3;
            cnt     <= 2'd0;
            ctrl_q  <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            cnt     <= cnt_nx;
            ctrl_q  <= ctrl_nx;
            grant_q <= grant_nx;
            done_q  <= done_nx;
            busy_q  <= busy_nx;
        end
    end

    assign bus.mem_ctrl = ctrl_q;
    assign bus.grant    = grant_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    mem_arbiter_if ifa ();
    mem_arbiter_if ifb ();

    mem_arbiter #(.RD_LAT(1)) dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa));
    mem_arbiter #(.RD_LAT(3)) dut_b (.clk(clk), .rst_n(rst_b), .bus(ifb));

    typedef struct {
        int          cyc;
        logic [12:0] mc;
        logic [3:0]  grant;
        logic [3:0]  done;
        bit          chk_dr;
        int          dr_idx;
        logic [15:0] dr_val;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Environment for DUT A: address/data buses, RAM with registered address
    // (RD_LAT=1) and the four data registers, all steered by mem_ctrl.
    logic [15:0] c_ar[4];
    logic [15:0] wdata[4];
    logic [15:0] dr[4];
    logic [15:0] ram[256];
    bit          ram_valid[256];
    logic [15:0] exp_mem[256];
    logic [15:0] addr_bus, data_bus, addr_reg, q;

    always_comb begin
        addr_bus = '0;
        data_bus = '0;
        for (int i = 0; i < 4; i++) begin
            if (ifa.mem_ctrl[4+i]) addr_bus = addr_bus | c_ar[i];
            if (ifa.mem_ctrl[8+i]) data_bus = data_bus | wdata[i];
        end
    end

    assign q = ram_valid[addr_reg[7:0]] ? ram[addr_reg[7:0]]
                                        : (16'hA000 | {8'h00, addr_reg[7:0]});

    always @(posedge clk) begin
        if (ifa.mem_ctrl[12]) begin
            ram[addr_bus[7:0]]       <= data_bus;
            ram_valid[addr_bus[7:0]] <= 1'b1;
        end
        if (|ifa.mem_ctrl[7:4]) addr_reg <= addr_bus;
        for (int i = 0; i < 4; i++)
            if (ifa.mem_ctrl[i]) dr[i] <= q;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic int qsize(input bit b);
        return b ? qb.size() : qa.size();
    endfunction

    function automatic int qfront_cyc(input bit b);
        return b ? qb[0].cyc : qa[0].cyc;
    endfunction

    task automatic qpop(input bit b, output exp_t e);
        if (b) e = qb.pop_front();
        else   e = qa.pop_front();
    endtask

    task automatic qpush(input bit b, input exp_t e);
        if (b) qb.push_back(e);
        else   qa.push_back(e);
    endtask

    task automatic mon(input bit b, input logic busy, input logic [12:0] mc,
                       input logic [3:0] g, input logic [3:0] d);
        exp_t  e;
        string tag = b ? "B" : "A";
        if (busy) begin
            checks++;
            if (qsize(b) == 0) begin
                errors++;
                $display("FAIL %s unexpected busy at cycle %0d: mem_ctrl=%h grant=%b done=%b",
                         tag, cycle, mc, g, d);
            end else begin
                qpop(b, e);
                if (e.cyc != cycle || mc !== e.mc || g !== e.grant || d !== e.done) begin
                    errors++;
                    $display("FAIL %s step: got cyc=%0d mem_ctrl=%h grant=%b done=%b, want cyc=%0d mem_ctrl=%h grant=%b done=%b",
                             tag, cycle, mc, g, d, e.cyc, e.mc, e.grant, e.done);
                end
                if (e.chk_dr) chk({tag, " dr"}, {16'h0, dr[e.dr_idx]}, {16'h0, e.dr_val});
            end
        end else begin
            chk({tag, " idle outputs"}, {11'h0, mc, g, d}, 32'h0);
            if (qsize(b) > 0 && qfront_cyc(b) < cycle) begin
                checks++;
                errors++;
                qpop(b, e);
                $display("FAIL %s missing step: idle at cycle %0d, want cyc=%0d mem_ctrl=%h",
                         tag, cycle, e.cyc, e.mc);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(1'b0, ifa.busy, ifa.mem_ctrl, ifa.grant, ifa.done);
        mon(1'b1, ifb.busy, ifb.mem_ctrl, ifb.grant, ifb.done);
    end

    // t0 is the IDLE cycle in which the request is first sampled.
    task automatic push_read(input bit b, input int core, input int t0, input int lat);
        exp_t       e;
        logic [3:0] oh = 4'(1 << core);
        e.grant  = oh;
        e.done   = 4'h0;
        e.chk_dr = 1'b0;
        e.dr_idx = core;
        e.dr_val = 16'h0;
        for (int k = 0; k < lat; k++) begin
            e.cyc = t0 + 1 + k;
            e.mc  = {5'b0, oh, 4'b0};
            qpush(b, e);
        end
        e.cyc = t0 + 1 + lat;
        e.mc  = {5'b0, oh, oh};
        qpush(b, e);
        e.cyc    = t0 + 2 + lat;
        e.mc     = 13'h0;
        e.done   = oh;
        e.chk_dr = !b;
        e.dr_val = exp_mem[c_ar[core][7:0]];
        qpush(b, e);
    endtask

    task automatic push_write(input int core, input int t0);
        exp_t       e;
        logic [3:0] oh = 4'(1 << core);
        e.grant  = oh;
        e.done   = 4'h0;
        e.chk_dr = 1'b0;
        e.dr_idx = core;
        e.dr_val = 16'h0;
        e.cyc    = t0 + 1;
        e.mc     = {1'b1, oh, oh, 4'b0};
        qpush(1'b0, e);
        e.cyc  = t0 + 2;
        e.mc   = 13'h0;
        e.done = oh;
        qpush(1'b0, e);
        exp_mem[c_ar[core][7:0]] = wdata[core];
    endtask

    initial begin
        rst_a   = 1'b0;
        rst_b   = 1'b0;
        ifa.req = 4'h0;
        ifa.we  = 4'h0;
        ifb.req = 4'h0;
        ifb.we  = 4'h0;
        for (int i = 0; i < 256; i++) exp_mem[i] = 16'hA000 | 16'(i);
        for (int i = 0; i < 4; i++) begin
            c_ar[i]  = 16'h0011 + 16'(i);
            wdata[i] = 16'h0;
        end

        repeat (2) @(negedge clk);
        chk("reset mem_ctrl", {19'h0, ifa.mem_ctrl}, 32'h0);
        chk("reset grant",    {28'h0, ifa.grant},    32'h0);
        chk("reset done",     {28'h0, ifa.done},     32'h0);
        chk("reset busy",     {31'h0, ifa.busy},     32'h0);
        chk("reset B busy",   {31'h0, ifb.busy},     32'h0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);

        // Four simultaneous reads held high: 0001,0010,0100,1000,0001, 4 cycles apart.
        for (int n = 0; n < 5; n++) push_read(1'b0, n % 4, cycle + 4 * n, 1);
        ifa.req = 4'b1111;
        repeat (19) @(negedge clk);
        ifa.req = 4'h0;
        @(negedge clk);

        // Single read, core 3: 13'h0040, 13'h0044, done at t+3.
        c_ar[2] = 16'h0025;
        push_read(1'b0, 2, cycle, 1);
        ifa.req = 4'b0100;
        repeat (3) @(negedge clk);
        ifa.req = 4'h0;
        @(negedge clk);

        // Single write, core 1: 13'h1110 for one cycle; we flips after grant.
        c_ar[0]  = 16'h0010;
        wdata[0] = 16'hBEEF;
        push_write(0, cycle);
        ifa.req = 4'b0001;
        ifa.we  = 4'b0001;
        @(negedge clk);
        ifa.we  = 4'b0000;
        @(negedge clk);
        ifa.req = 4'h0;
        @(negedge clk);

        // Core 2 reads back the written word.
        c_ar[1] = 16'h0010;
        chk("readback model", {16'h0, exp_mem[8'h10]}, 32'h0000BEEF);
        push_read(1'b0, 1, cycle, 1);
        ifa.req = 4'b0010;
        repeat (3) @(negedge clk);
        ifa.req = 4'h0;
        @(negedge clk);

        // Fairness: core 2 just served, cores 1 and 2 request -> core 1 then core 2.
        c_ar[0] = 16'h0040;
        c_ar[1] = 16'h0041;
        push_read(1'b0, 0, cycle, 1);
        push_read(1'b0, 1, cycle + 4, 1);
        ifa.req = 4'b0011;
        repeat (7) @(negedge clk);
        ifa.req = 4'h0;
        @(negedge clk);

        // RD_LAT=3, core 4: 13'h0080 x3, 13'h0088, done at t+5; req drops in WAIT.
        push_read(1'b1, 3, cycle, 3);
        ifb.req = 4'b1000;
        repeat (2) @(negedge clk);
        ifb.req = 4'h0;
        repeat (3) @(negedge clk);
        @(negedge clk);

        // Reset pulse during CAPT of a core 3 read.
        c_ar[2] = 16'h0030;
        push_read(1'b0, 2, cycle, 1);
        ifa.req = 4'b0100;
        @(posedge clk);
        @(posedge clk);
        #2 rst_a = 1'b0;
        #1;
        chk("abort mem_ctrl", {19'h0, ifa.mem_ctrl}, 32'h0);
        chk("abort grant",    {28'h0, ifa.grant},    32'h0);
        chk("abort done",     {28'h0, ifa.done},     32'h0);
        chk("abort busy",     {31'h0, ifa.busy},     32'h0);
        qa.delete();
        ifa.req = 4'b1111;
        repeat (2) @(negedge clk);
        chk("abort dr3 kept", {16'h0, dr[2]}, 32'h0000A025);
        rst_a = 1'b1;
        push_read(1'b0, 0, cycle, 1);
        repeat (3) @(negedge clk);
        ifa.req = 4'h0;
        repeat (2) @(negedge clk);

        chk("queue A drained", 32'(qa.size()), 32'h0);
        chk("queue B drained", 32'(qb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin sequencer for the shared data memory in the 4-core system. It accepts read/write requests from cores 1..4 and grants the single memory port to one core at a time. It drives the 13-bit `mem_ctrl` word of the memory control block, which covers DR write enables, AR bus buffers, data bus buffers and RAM `wren`. Each transaction ends with a one-cycle `done` pulse to the owning core.

## Interface
- `RD_LAT`, default 1: cycles from the address edge until RAM `q` is valid on `mem_bus`. Legal range 1..4.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  per-core level request; bit i is core i+1.
- `we`  in  4  per-core access type: 1 = write, 0 = read. Sampled only at grant.
- `mem_ctrl`  out  13  control word:
  - [3:0] DR write enables
  - [7:4] AR bus enables
  - [11:8] data bus enables
  - [12] RAM wren
- `grant`  out  4  one-hot owner of the memory port; 0 when idle.
- `done`  out  4  one-cycle completion pulse to the owner.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ADDR, WAIT, CAPT, WR, DONE.
- All outputs are flop-driven (Moore), so no combinational path from `req` to any output.
- **IDLE**
  - If `req` is nonzero, pick the winner by round-robin, starting at `ptr+1` mod 4.
  - Load `grant`, latch `we[winner]`, set `ptr` to the winner.
  - Go to WR if the latched `we` is 1, else ADDR.
- **ADDR** (read): `mem_ctrl[4+i]` = 1. The RAM registers the address at the end of this cycle.
- **WAIT** (read): `mem_ctrl[4+i]` held at 1 for RD_LAT-1 cycles via a down-counter. Skipped when RD_LAT = 1.
- **CAPT** (read): `mem_ctrl[4+i]` = 1 and `mem_ctrl[i]` = 1, so DR_i latches `mem_bus` at the end of this cycle.
- **WR** (write): `mem_ctrl[4+i]`, `mem_ctrl[8+i]` and `mem_ctrl[12]` = 1 for exactly one cycle.
- **DONE**
  - `done[i]` = 1 and `mem_ctrl` = 0.
  - `grant` is still held.
  - `req` is ignored this cycle; next state is IDLE.
- Invariants:
  - At most one bit set in each of `mem_ctrl[3:0]`, [7:4] and [11:8].
  - `mem_ctrl[12]` is set only in WR.
  - `mem_ctrl` is 0 in IDLE and DONE.
- Requester contract:
  - Hold the address on `cN_AR` and the write data on `dataN` from the first `req` cycle through `done`.
  - Deassert `req` on the edge that samples `done`, unless it wants another access.
  - A `req` still high in the IDLE that follows counts as a new request.
- `req` dropping mid-transaction is ignored; the transaction completes.
- `we` changing after grant has no effect.

## Timing
- Reset (asynchronous, immediate):
  - State to IDLE, `ptr` to 3 (so core 1 has first priority).
  - `mem_ctrl`, `grant`, `done` and `busy` all 0; WAIT counter 0.
- Reset asserted mid-transaction aborts it: no `done`, `mem_ctrl` cleared at once, DR contents left as they are.
- Read, with `req` first seen in IDLE at cycle t:
  - ADDR at t+1, WAIT at t+2 .. t+RD_LAT, CAPT at t+1+RD_LAT, DONE at t+2+RD_LAT.
  - DR_i is valid from the DONE cycle onward.
  - Total is RD_LAT+3 cycles including IDLE; RD_LAT=1 gives 4 cycles.
- Write at cycle t: WR at t+1, DONE at t+2, for 3 cycles total.
- Back-to-back: after DONE there is always exactly one IDLE cycle before the next grant.
- With all four cores continuously requesting reads, each core gets one access per 4×(RD_LAT+3) cycles; no core starves.
- Arbitration among simultaneous requests is decided only in IDLE. New requests that arrive during a transaction wait for the next IDLE.

## Test plan
- **Single read, core 3, RD_LAT=1.** Stimulus: `req`=4'b0100, `we`=0. Required response:
  - ADDR `mem_ctrl`=13'h0040, CAPT 13'h0044, then `done`=4'b0100 at t+3.
  - DR3 holds the RAM word preloaded at `c3_AR`.
- **Single write, core 1.** Stimulus: `req`=4'b0001, `we`=1, `c1_AR`=16'h0010, `data1`=16'hBEEF. Required response:
  - WR `mem_ctrl`=13'h1110 for exactly 1 cycle; `done`=4'b0001 at t+2.
  - A subsequent core 2 read of 16'h0010 returns 16'hBEEF.
- **Four simultaneous reads held high after reset.** Required response:
  - Grants in order 0001, 0010, 0100, 1000, 0001.
  - Grant starts spaced 4 cycles apart for RD_LAT=1.
  - One `done` per grant.
- **Fairness.** Stimulus: core 2 just served, then cores 1 and 2 both requesting. Required response: core 1 is granted next, then core 2.
- **RD_LAT=3, core 4 read.** Required response:
  - `mem_ctrl`=13'h0080 for 3 cycles, CAPT 13'h0088, `done` at t+5.
  - `req` dropped during WAIT still completes.
- **Reset pulse during CAPT.** Required response:
  - `mem_ctrl`, `grant`, `done` and `busy` go to 0 without waiting for a clock edge.
  - After release with `req`=4'b1111, the first grant is 4'b0001.
